// File: rtl/memdev_if.sv
// MEM-stage memory-device port: byte address, store data and op code from
// stage_mem; load result, stall request and misalignment pulse back to it.
interface memdev_if;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic [2:0]  opt;
    logic [31:0] data_in;
    logic        busy;
    logic        misalign;

    modport master (
        output addr,
        output data_out,
        output opt,
        input  data_in,
        input  busy,
        input  misalign
    );

    modport slave (
        input  addr,
        input  data_out,
        input  opt,
        output data_in,
        output busy,
        output misalign
    );
endinterface

// File: rtl/memdev_sram_ctrl.sv
// Multi-cycle bridge from the MEM-stage memdev port to a 32-bit asynchronous SRAM
// with per-byte write enables; stalls the pipeline until each access completes.
module memdev_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    memdev_if.slave               memdev,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n,
    output logic                  sram_drive
);

    localparam logic [2:0] OPT_LW  = 3'b001;
    localparam logic [2:0] OPT_LB  = 3'b010;
    localparam logic [2:0] OPT_LBU = 3'b011;
    localparam logic [2:0] OPT_SW  = 3'b100;
    localparam logic [2:0] OPT_SB  = 3'b101;

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       opt_r;
    logic [1:0]       byte_sel_r;
    logic [31:0]      data_in_r;
    logic             misalign_r;

    logic             is_load_s;
    logic             is_store_s;
    logic             word_op_s;
    logic             misalign_s;
    logic             accept_s;
    logic             busy_s;
    logic             unused_addr_s;

    // Pick the addressed byte lane and extend it according to the load kind.
    function automatic logic [31:0] fmt_load(input logic [2:0]  opt,
                                             input logic [1:0]  sel,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [31:0] res;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        case (opt)
            OPT_LB:  res = {{24{b[7]}}, b};
            OPT_LBU: res = {24'h000000, b};
            default: res = word;
        endcase
        return res;
    endfunction

    // Byte-lane enables for a store: full word for SW, one lane for SB.
    function automatic logic [3:0] store_be_n(input logic [2:0] opt, input logic [1:0] sel);
        logic [3:0] be;
        case (opt)
            OPT_SB:  be = ~(4'b0001 << sel);
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Decode the presented op code; unlisted codes behave as NONE.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        word_op_s  = 1'b0;
        case (memdev.opt)
            OPT_LW: begin
                is_load_s = 1'b1;
                word_op_s = 1'b1;
            end
            OPT_LB, OPT_LBU: begin
                is_load_s = 1'b1;
            end
            OPT_SW: begin
                is_store_s = 1'b1;
                word_op_s  = 1'b1;
            end
            OPT_SB: begin
                is_store_s = 1'b1;
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
                word_op_s  = 1'b0;
            end
        endcase
    end

    assign misalign_s = word_op_s & (memdev.addr[1:0] != 2'b00);
    assign accept_s   = (is_load_s | is_store_s) & ~misalign_s;

    // Stall request; gated by reset so an aborted access releases the pipeline at once.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            ST_IDLE:                               busy_s = accept_s;
            ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: busy_s = 1'b1;
            default:                               busy_s = 1'b0;
        endcase
        if (!rst) begin
            busy_s = 1'b0;
        end else begin
            busy_s = busy_s;
        end
    end

    assign memdev.busy     = busy_s;
    assign memdev.data_in  = data_in_r;
    assign memdev.misalign = misalign_r;

    // Upper address bits alias onto the SRAM word space.
    assign unused_addr_s = ^memdev.addr[31:ADDR_WIDTH+2];

    // Access FSM; every SRAM strobe is a register so the pads see glitch-free edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            opt_r      <= 3'b000;
            byte_sel_r <= 2'b00;
            data_in_r  <= 32'h0000_0000;
            misalign_r <= 1'b0;
            sram_addr  <= {ADDR_WIDTH{1'b0}};
            sram_wdata <= 32'h0000_0000;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
            sram_drive <= 1'b0;
        end else begin
            misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    misalign_r <= misalign_s;
                    if (accept_s) begin
                        opt_r      <= memdev.opt;
                        byte_sel_r <= memdev.addr[1:0];
                        cnt_r      <= CNT_LOAD;
                        sram_addr  <= memdev.addr[ADDR_WIDTH+1:2];
                        if (is_load_s) begin
                            state_r   <= ST_RD;
                            sram_oe_n <= 1'b0;
                            sram_be_n <= 4'b0000;
                        end else begin
                            state_r    <= ST_WR_SETUP;
                            sram_drive <= 1'b1;
                            sram_be_n  <= store_be_n(memdev.opt, memdev.addr[1:0]);
                            sram_wdata <= (memdev.opt == OPT_SB) ? {4{memdev.data_out[7:0]}}
                                                                 : memdev.data_out;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt_r == CNT_ZERO) begin
                        data_in_r <= fmt_load(opt_r, byte_sel_r, sram_rdata);
                        sram_oe_n <= 1'b1;
                        sram_be_n <= 4'hF;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt_r     <= CNT_LOAD;
                    state_r   <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt_r == CNT_ZERO) begin
                        sram_we_n <= 1'b1;
                        state_r   <= ST_WR_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_WR_HOLD: begin
                    sram_drive <= 1'b0;
                    sram_be_n  <= 4'hF;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_be_n  <= 4'hF;
                    sram_drive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// Bus-protocol invariants for the SRAM side of memdev_sram_ctrl.
module memdev_sram_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic sram_oe_n,
    input logic sram_we_n,
    input logic sram_drive
);
    a_oe_we_excl: assert property (@(posedge clk) disable iff (!rst)
        !(!sram_oe_n && !sram_we_n));

    a_no_drive_on_read: assert property (@(posedge clk) disable iff (!rst)
        !sram_oe_n |-> !sram_drive);
endmodule

// File: tb/tb_memdev_sram_ctrl.sv
// Scoreboard bench for memdev_sram_ctrl: directed ops push expected results,
// a negedge monitor pops and compares each time an access finishes.
module tb_memdev_sram_ctrl;

    localparam logic [2:0] OPT_NONE = 3'b000;
    localparam logic [2:0] OPT_LW   = 3'b001;
    localparam logic [2:0] OPT_LB   = 3'b010;
    localparam logic [2:0] OPT_LBU  = 3'b011;
    localparam logic [2:0] OPT_SW   = 3'b100;
    localparam logic [2:0] OPT_SB   = 3'b101;

    typedef struct {
        logic        is_store;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        logic [31:0] data_in;
        int          busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic        sram_drive;
    logic [31:0] mem [0:255];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    memdev_if mif ();

    memdev_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_WIDTH(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .memdev     (mif),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_be_n  (sram_be_n),
        .sram_drive (sram_drive)
    );

    memdev_sram_ctrl_chk chk (
        .clk        (clk),
        .rst        (rst),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_drive (sram_drive)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM model: byte-masked writes while we_n is low, combinational reads.
    always @(posedge clk) begin
        if (!sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end
    assign sram_rdata = sram_oe_n ? 32'h0000_0000 : mem[sram_addr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic is_store, input logic [3:0] be_n, input logic [31:0] wdata,
                        input logic [31:0] data_in, input int busy);
        exp_t e;
        e.is_store = is_store;
        e.be_n     = be_n;
        e.wdata    = wdata;
        e.data_in  = data_in;
        e.busy     = busy;
        exp_q.push_back(e);
    endtask

    // Present one op and hold it, as stage_mem does, until busy drops (DONE).
    task automatic do_op(input logic [2:0] opt, input logic [31:0] addr,
                         input logic [31:0] data, input bit mid_change);
        bit done = 1'b0;
        @(posedge clk); #1;
        mif.opt      = opt;
        mif.addr     = addr;
        mif.data_out = data;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mid_change && k == 1) begin
                mif.addr     = 32'h0000_0080;
                mif.data_out = 32'hFFFF_FFFF;
            end
            if (mid_change && k == 2) check("mid_rd_sram_addr", {12'h000, sram_addr}, 32'h0000_0010);
            if (!mif.busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("op_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: strobe invariants every cycle and scoreboard compare at the end of each access.
    initial begin
        int          busy_cnt = 0;
        logic [3:0]  seen_be  = 4'hF;
        logic [31:0] seen_wd  = 32'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt = 0;
            end else begin
                if (!sram_we_n) begin
                    seen_be = sram_be_n;
                    seen_wd = sram_wdata;
                    check("drive_during_we", {31'h0, sram_drive}, 32'd1);
                end
                if (!sram_oe_n || !sram_we_n)
                    check("oe_we_exclusive", {31'h0, (!sram_oe_n && !sram_we_n)}, 32'd0);
                if (!sram_oe_n) check("no_drive_during_oe", {31'h0, sram_drive}, 32'd0);
                if (mif.busy) begin
                    busy_cnt++;
                end else if (busy_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_access", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
                        check("data_in", mif.data_in, e.data_in);
                        if (e.is_store) begin
                            check("write_be_n", {28'h0, seen_be}, {28'h0, e.be_n});
                            check("write_data", seen_wd, e.wdata);
                        end
                    end
                    busy_cnt = 0;
                    seen_be  = 4'hF;
                    seen_wd  = 32'h0;
                end
            end
        end
    end

    initial begin
        bit found = 1'b0;
        rst          = 1'b0;
        mif.opt      = OPT_NONE;
        mif.addr     = 32'h0;
        mif.data_out = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_oe_n",     {31'h0, sram_oe_n},  32'd1);
        check("rst_we_n",     {31'h0, sram_we_n},  32'd1);
        check("rst_be_n",     {28'h0, sram_be_n},  32'h0000_000F);
        check("rst_drive",    {31'h0, sram_drive}, 32'd0);
        check("rst_addr",     {12'h0, sram_addr},  32'h0);
        check("rst_wdata",    sram_wdata,          32'h0);
        check("rst_data_in",  mif.data_in,         32'h0);
        check("rst_misalign", {31'h0, mif.misalign}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Reset asserted in the middle of a write pulse.
        @(posedge clk); #1;
        mif.opt = OPT_SW; mif.addr = 32'h0000_0010; mif.data_out = 32'h1234_5678;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_pulse", {31'h0, found}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_we_n",  {31'h0, sram_we_n},  32'd1);
        check("abort_drive", {31'h0, sram_drive}, 32'd0);
        check("abort_busy",  {31'h0, mif.busy},   32'd0);
        check("abort_be_n",  {28'h0, sram_be_n},  32'h0000_000F);
        mif.opt = OPT_NONE;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'h0, mif.busy},  32'd0);
        check("post_rst_oe_n", {31'h0, sram_oe_n}, 32'd1);
        check("post_rst_we_n", {31'h0, sram_we_n}, 32'd1);

        // Word store/load, then byte store and sign/zero-extended byte loads.
        push(1'b1, 4'b0000, 32'hDEAD_BEEF, 32'h0000_0000, 5);
        do_op(OPT_SW, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 3);
        do_op(OPT_LW, 32'h0000_0010, 32'h0, 1'b0);
        push(1'b1, 4'b0111, 32'h8080_8080, 32'hDEAD_BEEF, 5);
        do_op(OPT_SB, 32'h0000_0013, 32'h0000_0080, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'hFFFF_FF80, 3);
        do_op(OPT_LB, 32'h0000_0013, 32'h0, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'h0000_0080, 3);
        do_op(OPT_LBU, 32'h0000_0013, 32'h0, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'hFFFF_FFBE, 3);
        do_op(OPT_LB, 32'h0000_0011, 32'h0, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'h0000_00AD, 3);
        do_op(OPT_LBU, 32'h0000_0012, 32'h0, 1'b0);
        push(1'b1, 4'b1110, 32'h1515_1515, 32'h0000_00AD, 5);
        do_op(OPT_SB, 32'h0000_0010, 32'hAAAA_5515, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'h80AD_BE15, 3);
        do_op(OPT_LW, 32'h0000_0010, 32'h0, 1'b0);

        // Misaligned word accesses: one-cycle pulse, no stall, no strobes.
        for (int m = 0; m < 2; m++) begin
            @(posedge clk); #1;
            mif.opt  = (m == 0) ? OPT_LW : OPT_SW;
            mif.addr = (m == 0) ? 32'h0000_0022 : 32'h0000_0021;
            @(negedge clk);
            check("mis_busy",      {31'h0, mif.busy},     32'd0);
            check("mis_pre_pulse", {31'h0, mif.misalign}, 32'd0);
            @(posedge clk); #1 mif.opt = OPT_NONE;
            @(negedge clk);
            check("mis_pulse",  {31'h0, mif.misalign}, 32'd1);
            check("mis_oe_n",   {31'h0, sram_oe_n},    32'd1);
            check("mis_we_n",   {31'h0, sram_we_n},    32'd1);
            @(negedge clk);
            check("mis_pulse_end", {31'h0, mif.misalign}, 32'd0);
        end

        // Back-to-back: each op presented in the cycle right after the previous DONE.
        push(1'b0, 4'hF, 32'h0, 32'h80AD_BE15, 3);
        do_op(OPT_LW, 32'h0000_0010, 32'h0, 1'b0);
        push(1'b1, 4'b0000, 32'hCAFE_F00D, 32'h80AD_BE15, 5);
        do_op(OPT_SW, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 3);
        do_op(OPT_LW, 32'h0000_0020, 32'h0, 1'b0);

        // Inputs change mid-read: result still comes from the latched address.
        push(1'b1, 4'b0000, 32'h1122_3344, 32'hCAFE_F00D, 5);
        do_op(OPT_SW, 32'h0000_0040, 32'h1122_3344, 1'b0);
        push(1'b1, 4'b0000, 32'h5566_7788, 32'hCAFE_F00D, 5);
        do_op(OPT_SW, 32'h0000_0080, 32'h5566_7788, 1'b0);
        push(1'b0, 4'hF, 32'h0, 32'h1122_3344, 3);
        do_op(OPT_LW, 32'h0000_0040, 32'h0, 1'b1);

        // Address bits above the SRAM range alias back onto word 4.
        push(1'b0, 4'hF, 32'h0, 32'h80AD_BE15, 3);
        do_op(OPT_LW, 32'h0040_0010, 32'h0, 1'b0);

        // Reserved op code behaves as NONE.
        @(posedge clk); #1;
        mif.opt = 3'b111; mif.addr = 32'h0000_0010;
        repeat (3) begin
            @(negedge clk);
            check("reserved_opt_busy", {31'h0, mif.busy}, 32'd0);
        end
        mif.opt = OPT_NONE;

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
